anemo_freq_meter: RTL and testbench
===================================

Name: anemo_freq_meter

Overview:
- Avalon-MM slave peripheral that measures the anemometer's square-wave pulse frequency over a fixed gate window.
- Publishes the result to the Nios II through two registers.
- Sits directly upstream of the SOPC's anemometer conduit: it consumes the raw anemometer pin and is the component behind the avalon_anemo_0 instance.
- Supports continuous measurement and single-shot measurement triggered by software.

Parameters:
- GATE_CYCLES, 50000000, clk cycles per measurement window (1 s at 50 MHz; benches use 1000).
- FREQ_W, 8, width of the frequency result in pulses per window.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous active-low reset.
- in_freq_anemometre  in  1  raw anemometer pulse, asynchronous to clk.
- chipselect  in  1  Avalon slave select.
- address  in  1  register select: 0 = CONFIG, 1 = DATA.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  write data.
- readdata  out  32  read data.

Behaviour:
- Reset: all outputs and all state are zero after reset_n low. State = IDLE, freq = 0, data_valid = 0, CONFIG = 0x0. Reset is asynchronous assert, synchronous release via a 2-FF reset synchroniser.
- Input conditioning:
  - in_freq_anemometre passes through a 2-FF synchroniser, then a rising-edge detector.
  - The detector produces a one-cycle pulse `edge`.
  - Latency from pin to edge is 3 clk cycles.
- CONFIG register (addr 0, R/W):
  - bit0 raz_n: soft clear, active-low.
  - bit1 continu: 1 = continuous, 0 = single-shot.
  - bit2 start_stop: single-shot trigger.
  - Bits 31:3 read as 0.
- DATA register (addr 1, RO):
  - bits FREQ_W-1:0 = freq.
  - bit 9 = data_valid.
  - All other bits read 0.
  - Writes to addr 1 are ignored.
- Bus timing:
  - A write occurs when chipselect=1 and write_n=0; it takes effect on the next clk edge.
  - readdata is combinational from address (zero wait states).
- Soft clear: while raz_n=0, the state machine is held in IDLE, the counters are held at 0, freq = 0 and data_valid = 0.
- State machine IDLE / MEASURE / DONE:
  - IDLE → MEASURE when raz_n=1 AND (continu=1 OR a start_stop 0→1 transition is written). Entering MEASURE clears gate_cnt and edge_cnt.
  - In MEASURE:
    - gate_cnt counts 0..GATE_CYCLES-1.
    - edge_cnt increments on each edge and saturates at 2^FREQ_W-1 (no wrap).
  - End of window (gate_cnt = GATE_CYCLES-1):
    - An edge arriving on this cycle is counted in the ending window.
    - freq ← final edge_cnt and data_valid ← 1, both on the following clk edge.
    - Then go to DONE.
  - DONE, one cycle: if continu=1, go to MEASURE with counters cleared (window-to-window gap ≤ 1 cycle); otherwise go to IDLE.
- data_valid, single-shot:
  - Cleared on the cycle a start_stop 0→1 starts a window.
  - Set at window end.
- data_valid, continuous: stays 1 after the first window; freq updates atomically at each window end.
- start_stop written while in MEASURE is ignored, i.e. no restart; the 0→1 trigger is tracked against the register's previous value.
- continu 1→0 mid-window: the current window completes and publishes, then the block goes to IDLE.
- raz_n written to 0 mid-window: the window is aborted immediately and nothing is published.
- Hardware reset mid-window: identical to soft clear, plus CONFIG returns to 0.

Test Plan:
(GATE_CYCLES=1000, clk 50 MHz)
- Reset: drive reset_n low for 5 cycles mid-activity → readdata at addr 0 and addr 1 = 0x0; no edge counted for 3 cycles after release.
- Continuous mode: write CONFIG=0x3; apply a 20-cycle-period pin square wave for 3 windows → each window publishes freq=50, DATA=0x232; data_valid never drops after the first window.
- Single-shot:
  - Write CONFIG=0x1, then CONFIG=0x5; pin period 40 cycles → during the window DATA bit 9 = 0; after ~1000 cycles DATA=0x219 (freq=25); the block stays IDLE afterwards.
  - A second write of 0x5 without clearing bit 2 → no new window.
- Saturation: pin period 2 cycles (500 edges/window) with FREQ_W=8 → freq=255, DATA=0x2FF.
- Boundary edge: pulse timed so that edge is asserted exactly on gate_cnt=999 → the edge is counted in that window; the next window starts from 0.
- Abort: in continuous mode, write CONFIG=0x2 (raz_n=0) at cycle 500 of a window → freq=0 and data_valid=0 next cycle; write 0x3 → a fresh full window publishes the correct value.

Source files
------------

// File: rtl/anemo_freq_meter.sv
// anemo_freq_meter
// ----------------
// Avalon-MM slave that counts rising edges of the anemometer pulse over a
// fixed gate window of GATE_CYCLES clocks. The result is read back by
// software from the DATA register.
//
// Ports:
//   clk                 system clock
//   reset_n             asynchronous active-low reset (released synchronously)
//   in_freq_anemometre  raw anemometer pulse, asynchronous to clk
//   chipselect          Avalon slave select
//   address             0 = CONFIG (R/W), 1 = DATA (RO)
//   write_n             Avalon write strobe, active-low
//   writedata           write data (only bits 2:0 are used)
//   readdata            read data, combinational from address
//
// CONFIG: bit0 raz_n (soft clear, active-low), bit1 continu, bit2 start_stop.
// DATA:   bits FREQ_W-1:0 = freq, bit 9 = data_valid. FREQ_W must not exceed 9.

module anemo_freq_meter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned FREQ_W      = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_freq_anemometre,
    input  logic        chipselect,
    input  logic        address,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);

    localparam int unsigned        GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [FREQ_W-1:0]  EDGE_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Reset synchroniser: asserts immediately, releases two clocks after
    // reset_n rises so no flop sees reset removal near a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // Pin conditioning: two synchroniser stages, one history stage and a
    // registered rising-edge pulse, giving three clocks from pin to pin_edge.
    logic [2:0] pin_sync;
    logic       pin_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_sync <= '0;
            pin_edge <= 1'b0;
        end else begin
            pin_sync <= {pin_sync[1:0], in_freq_anemometre};
            pin_edge <= pin_sync[1] & ~pin_sync[2];
        end
    end

    // CONFIG register
    logic [2:0] cfg;
    logic       cfg_wr;
    logic       start_req;
    logic       raz_n;
    logic       continu;

    assign cfg_wr    = chipselect & ~write_n & ~address;
    // A trigger is a 0->1 of start_stop relative to the value already held.
    assign start_req = cfg_wr & writedata[2] & ~cfg[2];
    assign raz_n     = cfg[0];
    assign continu   = cfg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cfg <= '0;
        else if (cfg_wr) cfg <= writedata[2:0];
    end

    // Measurement state machine
    state_t              state, state_next;
    logic [GATE_W-1:0]   gate_cnt;
    logic [FREQ_W-1:0]   edge_cnt;
    logic [FREQ_W-1:0]   edge_next;
    logic [FREQ_W-1:0]   freq;
    logic                data_valid;
    logic                window_end;

    assign window_end = (state == MEASURE) && (gate_cnt == GATE_LAST);
    // Saturating count; an edge on the last window cycle still lands here.
    assign edge_next  = (pin_edge && (edge_cnt != EDGE_MAX)) ? edge_cnt + 1'b1 : edge_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next is given its default before the case so no path
    // through this block leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (continu || start_req) state_next = MEASURE;
            MEASURE: if (window_end)           state_next = DONE;
            DONE:    state_next = continu ? MEASURE : IDLE;
            default: state_next = IDLE;
        endcase
        // Soft clear wins over everything, including an in-flight window.
        if (!raz_n) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            freq       <= '0;
            data_valid <= 1'b0;
        end else if (!raz_n) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            freq       <= '0;
            data_valid <= 1'b0;
        end else begin
            if (state != MEASURE && state_next == MEASURE) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
            end else if (state == MEASURE) begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= edge_next;
            end

            // A software-triggered window hides the previous result until
            // it completes; continuous mode keeps data_valid high throughout.
            if (state == IDLE && state_next == MEASURE && !continu)
                data_valid <= 1'b0;

            if (window_end) begin
                freq       <= edge_next;
                data_valid <= 1'b1;
            end
        end
    end

    // Read mux, zero wait states
    always_comb begin
        readdata = '0;
        if (!address) begin
            readdata[2:0] = cfg;
        end else begin
            readdata[FREQ_W-1:0] = freq;
            readdata[9]          = data_valid;
        end
    end

    logic unused_bits;
    assign unused_bits = ^writedata[31:3];

endmodule

// File: tb/tb_anemo_freq_meter.sv
// Testbench for anemo_freq_meter with GATE_CYCLES = 1000 and FREQ_W = 8.
// Expected DATA values are pushed to a queue when a window is launched and
// popped when the result is read back.

module tb_anemo_freq_meter;

    localparam int GATE = 1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pin;
    logic        chipselect;
    logic        address;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    int          checks   = 0;
    int          failures = 0;
    int          half     = 0;     // half period of pin square wave; 0 = manual
    int          phase    = 0;
    logic        manual_pin = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] rd;

    anemo_freq_meter #(
        .GATE_CYCLES(GATE),
        .FREQ_W     (8)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_freq_anemometre(pin),
        .chipselect        (chipselect),
        .address           (address),
        .write_n           (write_n),
        .writedata         (writedata),
        .readdata          (readdata)
    );

    always #10 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // One negedge step; also advances the pin waveform so it has one driver.
    task automatic tick();
        @(negedge clk);
        if (half > 0) begin
            phase++;
            if (phase >= half) begin
                phase = 0;
                pin   = ~pin;
            end
        end else begin
            pin = manual_pin;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [31:0] d);
        tick();
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 1'b0;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h required=0x%08h", tag, obs, req);
        end
    endtask

    task automatic check_data(input string tag);
        logic [31:0] v;
        logic [31:0] e;
        bus_read(1'b1, v);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check(tag, v, e);
    endtask

    task automatic wait_dv(input string tag, input int bound);
        logic [31:0] v;
        logic        ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            tick();
            bus_read(1'b1, v);
            ok = v[9];
        end
        check(tag, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        int drops;

        reset_n    = 1'b0;
        pin        = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 1'b0;
        writedata  = '0;

        // Reset state
        ticks(5);
        bus_read(1'b0, rd); check("reset_cfg",  rd, 32'h0);
        bus_read(1'b1, rd); check("reset_data", rd, 32'h0);
        reset_n = 1'b1;
        ticks(5);

        // Continuous mode, period 20 -> 50 edges per window, three windows
        half = 10;
        ticks(50);
        bus_write(32'h3);
        repeat (3) exp_q.push_back(32'h232);
        wait_dv("cont_first_to", 1200);
        check_data("cont_win1");
        bus_read(1'b0, rd); check("cont_cfg", rd, 32'h3);
        drops = 0;
        for (int i = 0; i < 2 * (GATE + 1) + 10; i++) begin
            tick();
            bus_read(1'b1, rd);
            if (!rd[9]) drops++;
            if (i == GATE + 10)     check_data("cont_win2");
            if (i == 2 * GATE + 11) check_data("cont_win3");
        end
        check("cont_dv_drops", 32'(drops), 32'd0);

        // Abort roughly half way into the next window
        ticks(490);
        bus_write(32'h2);
        tick();
        exp_q.push_back(32'h0);
        check_data("abort_data");
        bus_read(1'b0, rd); check("abort_cfg", rd, 32'h2);

        // Fresh continuous window after abort, period 40 -> 25 edges
        half = 20;
        ticks(100);
        bus_write(32'h3);
        exp_q.push_back(32'h219);
        wait_dv("fresh_to", 1200);
        check_data("fresh_win");

        // continu 1->0 mid-window: window completes and publishes
        ticks(300);
        bus_write(32'h1);
        exp_q.push_back(32'h219);
        ticks(1000);
        check_data("cont_off_publish");

        // Single-shot
        bus_write(32'h5);
        ticks(5);
        bus_read(1'b1, rd); check("ss_dv_low", {31'b0, rd[9]}, 32'd0);
        exp_q.push_back(32'h219);
        wait_dv("ss_to", 1200);
        check_data("ss_result");
        half = 10;
        ticks(1200);
        exp_q.push_back(32'h219);
        check_data("ss_stays_idle");
        bus_write(32'h5);
        ticks(1200);
        exp_q.push_back(32'h219);
        check_data("ss_rewrite_ignored");

        // Saturation, period 2 -> 500 edges clamps at 255
        bus_write(32'h1);
        half = 1;
        ticks(20);
        bus_write(32'h5);
        exp_q.push_back(32'h2FF);
        wait_dv("sat_to", 1200);
        check_data("sat_result");

        // Boundary: edge on the last window cycle is counted
        bus_write(32'h1);
        half       = 0;
        manual_pin = 1'b0;
        ticks(10);
        bus_write(32'h5);
        exp_q.push_back(32'h201);
        ticks(995);
        manual_pin = 1'b1;
        tick();
        ticks(5);
        manual_pin = 1'b0;
        wait_dv("bnd_last_to", 1200);
        check_data("bnd_last_counted");

        // One cycle later the window is already over: not counted
        bus_write(32'h1);
        ticks(10);
        bus_write(32'h5);
        exp_q.push_back(32'h200);
        ticks(996);
        manual_pin = 1'b1;
        tick();
        ticks(5);
        manual_pin = 1'b0;
        wait_dv("bnd_after_to", 1200);
        check_data("bnd_after_dropped");

        // Hardware reset mid-window
        half = 10;
        bus_write(32'h3);
        ticks(300);
        tick();
        reset_n = 1'b0;
        ticks(5);
        bus_read(1'b0, rd); check("hwrst_cfg",  rd, 32'h0);
        bus_read(1'b1, rd); check("hwrst_data", rd, 32'h0);
        reset_n = 1'b1;
        ticks(3);
        bus_read(1'b0, rd); check("hwrst_rel_cfg",  rd, 32'h0);
        bus_read(1'b1, rd); check("hwrst_rel_data", rd, 32'h0);
        ticks(5);
        bus_write(32'h3);
        exp_q.push_back(32'h232);
        wait_dv("post_reset_to", 1200);
        check_data("post_reset_win");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
